up_down_mod_counter: RTL and testbench
======================================

Name: up_down_mod_counter

Overview:
Parametrised N-bit up/down counter with a runtime modulus limit, a selectable step size, and wrap or saturate mode. It also provides synchronous load and clear, a registered wrap/clip event pulse, and sticky overflow/underflow flags. It is the general-purpose counter for timers, address generators and credit counters in the sequential building-block library.

Parameters:
N, 8, counter width in bits (N >= 2)
RESET_VAL, 0, value of Q after reset

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
en  input  1  synchronous count enable
up  input  1  1 = count up, 0 = count down
step  input  N  increment/decrement magnitude per enabled cycle
limit  input  N  maximum count value; legal range is 0..limit
sat  input  1  1 = saturate at 0/limit, 0 = modular wrap
clr  input  1  synchronous clear of Q to 0
load  input  1  synchronous load of load_val
load_val  input  N  value to load
clr_flags  input  1  synchronous clear of ovf and unf
Q  output  N  current count
evt  output  1  registered one-cycle pulse: previous cycle's update wrapped or clipped
ovf  output  1  sticky: an up count wrapped or clipped
unf  output  1  sticky: a down count wrapped or clipped
at_max  output  1  combinational, Q == limit
at_zero  output  1  combinational, Q == 0

Behaviour:
- Reset (asynchronous, any time, including mid-count): Q = RESET_VAL, evt = 0, ovf = 0, unf = 0. Outputs hold these values while reset is high.
- Q update priority per rising edge: clr > load > en > hold.
- clr: Q <= 0. Does not touch ovf/unf. evt <= 0.
- load: Q <= min(load_val, limit). evt <= 0. Flags unchanged.
- Effective step s = min(step, limit). s = 0 with en: Q holds and no event occurs.
- Arithmetic is done in N+1 bits so there is no intermediate overflow. Modulus M = limit + 1, evaluated in N+1 bits so limit = 2^N-1 gives M = 2^N.
- Out-of-range state: if Q > limit (limit lowered at runtime) on an enabled cycle:
  - wrap mode: Q <= 0.
  - sat mode: Q <= limit.
  - In both modes evt <= 1 and ovf <= 1, regardless of up.
- Up, in range: if Q + s <= limit, Q <= Q + s. Otherwise:
  - wrap mode: Q <= Q + s - M.
  - sat mode: Q <= limit.
  - In both cases evt <= 1 and ovf <= 1.
- Down, in range: if Q >= s, Q <= Q - s. Otherwise:
  - wrap mode: Q <= Q + M - s.
  - sat mode: Q <= 0.
  - In both cases evt <= 1 and unf <= 1.
- Saturated hold:
  - Q == limit with up, sat=1, s > 0: Q stays at limit, and evt and ovf are asserted on every such cycle.
  - Q == 0 with down, sat=1, s > 0: Q stays at 0, and evt and unf are asserted on every such cycle.
- evt is 0 on every cycle that does not meet the conditions above. Latency is one cycle: evt is high in the cycle after the edge that produced the wrap or clip.
- limit = 0: Q is forced to 0 on any enabled cycle. s = 0, so no event occurs unless Q was out of range.
- clr_flags clears ovf and unf. If clr_flags coincides with a new set condition on the same edge, the set wins.
- sat, up, step and limit are sampled only on enabled edges. A mode change takes effect on the next enabled edge; no other state is involved.
- at_max and at_zero are combinational from Q and limit.

Test Plan:
- N=8, reset pulsed mid-count at Q=37 -> Q=0, evt=0, ovf=0, unf=0 immediately, before any clock edge; counting resumes from 0 after reset falls.
- limit=9, sat=0, up=1, step=1, en held 10 cycles from Q=0 -> Q goes 1..9 then 0; evt pulses once, in the cycle after 9->0; ovf=1; at_max=1 while Q=9.
- limit=9, sat=0, up=1, step=4, Q=8 -> Q=2, ovf=1. Then up=0, step=3 from Q=2 -> Q=9, unf=1.
- limit=99, sat=1, up=0, step=3, Q=2 -> Q=0, unf=1. Next enabled cycle -> Q=0, evt=1 again. Then up=1 from Q=98 -> Q=99, then 99 with evt=1, ovf=1.
- load=1, load_val=200, limit=99 -> Q=99. clr=1, load=1 and en=1 on the same edge -> Q=0. clr_flags=1 on an edge where up wraps -> ovf stays 1.
- limit=255, step=1, up=1, sat=0, Q=255 -> Q=0, ovf=1. With Q=50, limit lowered to 20, en=1, sat=0 -> Q=0, evt=1, ovf=1.

Source files
------------

// File: rtl/up_down_mod_counter.sv
// Up/down counter with runtime modulus, variable step, wrap/saturate mode,
// sticky overflow/underflow flags and a registered wrap/clip event pulse.
module up_down_mod_counter #(
  parameter int unsigned    N         = 8,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] step,
  input  logic [N-1:0] limit,
  input  logic         sat,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         clr_flags,
  output logic [N-1:0] Q,
  output logic         evt,
  output logic         ovf,
  output logic         unf,
  output logic         at_max,
  output logic         at_zero
);

  logic [N-1:0] q_q, q_d;
  logic         evt_q, evt_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         ovf_set, unf_set;

  logic [N-1:0] s_eff;
  logic [N:0]   q_w, s_w, lim_w, mod_w, sum_w, wrap_up_w, wrap_dn_w;

  // One extra bit so limit = 2^N-1 yields modulus 2^N without overflow.
  always_comb begin
    s_eff     = (step < limit) ? step : limit;
    q_w       = {1'b0, q_q};
    s_w       = {1'b0, s_eff};
    lim_w     = {1'b0, limit};
    mod_w     = lim_w + {{N{1'b0}}, 1'b1};
    sum_w     = q_w + s_w;
    wrap_up_w = sum_w - mod_w;
    wrap_dn_w = q_w + mod_w - s_w;
  end

  always_comb begin
    q_d     = q_q;
    evt_d   = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = (load_val < limit) ? load_val : limit;
    end else if (en) begin
      if (q_q > limit) begin
        // Limit was lowered under us: treat as an overflow in either direction.
        q_d     = sat ? limit : '0;
        evt_d   = 1'b1;
        ovf_set = 1'b1;
      end else if (up) begin
        if (sum_w <= lim_w) begin
          q_d = sum_w[N-1:0];
        end else begin
          q_d     = sat ? limit : wrap_up_w[N-1:0];
          evt_d   = 1'b1;
          ovf_set = 1'b1;
        end
      end else begin
        if (q_q >= s_eff) begin
          q_d = q_q - s_eff;
        end else begin
          q_d     = sat ? '0 : wrap_dn_w[N-1:0];
          evt_d   = 1'b1;
          unf_set = 1'b1;
        end
      end
    end
    ovf_d = (ovf_q & ~clr_flags) | ovf_set;
    unf_d = (unf_q & ~clr_flags) | unf_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q   <= RESET_VAL;
      evt_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      evt_q <= evt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign Q       = q_q;
  assign evt     = evt_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign at_max  = (q_q == limit);
  assign at_zero = (q_q == '0);

endmodule

// File: tb/tb_up_down_mod_counter.sv
// Scoreboard bench for up_down_mod_counter: an integer reference model pushes
// the expected state per edge and the post-edge sample pops and compares it.
module tb_up_down_mod_counter;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0, up = 1'b1, sat = 1'b0;
  logic [N-1:0] step = '0, limit = '0, load_val = '0;
  logic         clr = 1'b0, load = 1'b0, clr_flags = 1'b0;
  logic [N-1:0] Q;
  logic         evt, ovf, unf, at_max, at_zero;

  up_down_mod_counter #(.N(N), .RESET_VAL(8'd0)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .step     (step),
    .limit    (limit),
    .sat      (sat),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .clr_flags(clr_flags),
    .Q        (Q),
    .evt      (evt),
    .ovf      (ovf),
    .unf      (unf),
    .at_max   (at_max),
    .at_zero  (at_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    bit evt;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state
  int m_q   = 0;
  bit m_ovf = 0;
  bit m_unf = 0;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic model_and_push();
    int lim, s, md, nq;
    bit e, o, u;
    exp_t x;
    lim = int'(limit);
    s   = (int'(step) < lim) ? int'(step) : lim;
    md  = lim + 1;
    nq  = m_q;
    e = 0; o = 0; u = 0;
    if (clr) nq = 0;
    else if (load) nq = (int'(load_val) < lim) ? int'(load_val) : lim;
    else if (en) begin
      if (m_q > lim) begin
        nq = sat ? lim : 0; e = 1; o = 1;
      end else if (up) begin
        if (m_q + s > lim) begin nq = sat ? lim : (m_q + s) % md; e = 1; o = 1; end
        else nq = m_q + s;
      end else begin
        if (m_q < s) begin nq = sat ? 0 : (m_q - s + md) % md; e = 1; u = 1; end
        else nq = m_q - s;
      end
    end
    m_q   = nq;
    m_ovf = (m_ovf && !clr_flags) || o;
    m_unf = (m_unf && !clr_flags) || u;
    x.q = m_q; x.evt = e; x.ovf = m_ovf; x.unf = m_unf;
    exp_q.push_back(x);
  endtask

  // Drive current inputs across one edge and compare against the scoreboard.
  task automatic cycle();
    exp_t x;
    model_and_push();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      x = exp_q.pop_front();
      check("q", int'(Q), x.q);
      check("evt", int'(evt), int'(x.evt));
      check("ovf", int'(ovf), int'(x.ovf));
      check("unf", int'(unf), int'(x.unf));
      check("at_max", int'(at_max), int'(x.q == int'(limit)));
      check("at_zero", int'(at_zero), int'(x.q == 0));
    end
  endtask

  task automatic idle_ctl();
    en = 0; clr = 0; load = 0; clr_flags = 0;
  endtask

  task automatic do_load(input logic [N-1:0] v);
    idle_ctl(); load = 1; load_val = v; cycle(); load = 0;
  endtask

  initial begin
    // Reset state
    limit = 8'd9;
    @(posedge clk); #1;
    check("rst_q", int'(Q), 0);
    check("rst_evt", int'(evt), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_unf", int'(unf), 0);
    @(negedge clk); reset = 0;

    // Wrap at limit 9, step 1
    sat = 0; up = 1; step = 1; en = 1;
    for (int i = 0; i < 10; i++) cycle();
    check("wrap9_q", int'(Q), 0);
    check("wrap9_evt", int'(evt), 1);
    check("wrap9_ovf", int'(ovf), 1);
    idle_ctl(); cycle();
    check("wrap9_evt_drop", int'(evt), 0);

    // Step 4 up from 8 wraps to 2; step 3 down from 2 wraps to 9
    do_load(8'd8);
    en = 1; step = 4; up = 1; cycle();
    check("up_step4_q", int'(Q), 2);
    up = 0; step = 3; cycle();
    check("dn_step3_q", int'(Q), 9);
    check("dn_step3_unf", int'(unf), 1);

    // Saturation with limit 99
    idle_ctl(); clr_flags = 1; cycle();
    limit = 8'd99; sat = 1; do_load(8'd2);
    en = 1; up = 0; step = 3; cycle(); cycle();
    check("sat_lo_q", int'(Q), 0);
    check("sat_lo_evt", int'(evt), 1);
    do_load(8'd98);
    en = 1; up = 1; step = 1; cycle(); cycle(); cycle();
    check("sat_hi_q", int'(Q), 99);
    check("sat_hi_ovf", int'(ovf), 1);

    // Load clamp, clr priority, clr_flags loses to a new set
    do_load(8'd200);
    check("load_clamp", int'(Q), 99);
    clr = 1; load = 1; en = 1; load_val = 8'd5; cycle();
    check("clr_prio", int'(Q), 0);
    idle_ctl(); clr_flags = 1; cycle();
    limit = 8'd9; sat = 0; do_load(8'd9);
    en = 1; up = 1; step = 1; clr_flags = 1; cycle();
    check("flag_set_wins", int'(ovf), 1);

    // Full-width modulus and lowered limit
    limit = 8'd255; do_load(8'd255);
    en = 1; up = 1; step = 1; sat = 0; cycle();
    check("full_wrap_q", int'(Q), 0);
    do_load(8'd50);
    limit = 8'd20; en = 1; cycle();
    check("oor_q", int'(Q), 0);
    check("oor_evt", int'(evt), 1);

    // Asynchronous reset mid-count at Q=37
    limit = 8'd99; do_load(8'd36);
    en = 1; up = 1; step = 1; cycle();
    check("pre_rst_q", int'(Q), 37);
    #2 reset = 1;
    #1;
    check("async_rst_q", int'(Q), 0);
    check("async_rst_flags", int'({evt, ovf, unf}), 0);
    @(posedge clk); #1;
    check("hold_rst_q", int'(Q), 0);
    @(negedge clk); reset = 0;
    m_q = 0; m_ovf = 0; m_unf = 0;
    for (int i = 0; i < 3; i++) cycle();
    check("resume_q", int'(Q), 3);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 9) < 8);
      up        = $urandom_range(0, 1);
      sat       = $urandom_range(0, 1);
      clr       = ($urandom_range(0, 29) == 0);
      load      = ($urandom_range(0, 14) == 0);
      clr_flags = ($urandom_range(0, 9) == 0);
      load_val  = 8'($urandom_range(0, 255));
      step      = 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) limit = 8'($urandom_range(0, 255));
      cycle();
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
